dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Sequencer that drives the `dds` tone generator's `freq`/`phase` inputs and the `dsdac` `en` input to produce linear frequency sweeps. Latches a sweep program on a start pulse, holds the DAC disabled while the DDS output settles, then steps the frequency word at a programmable dwell rate until the stop frequency is reached, and reports completion. Sits between the register/control side and the `dds` → `dsdac` datapath, all in the single `clk` domain.

## Interface
- `FREQ_W`, 32, width of frequency/phase words (matches `dds`)
- `DWELL_W`, 16, width of dwell counter
- `SETTLE_CYC`, 8, cycles DAC stays disabled after start (≥1)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: sweep request, sampled only in IDLE
- `abort` in 1: terminate any sweep
- `loop` in 1: restart sweep on completion, sampled in DONE
- `f_start` in FREQ_W: first frequency word
- `f_stop` in FREQ_W: final frequency word
- `f_step` in FREQ_W: increment per step (0 treated as 1)
- `dwell` in DWELL_W: each frequency held `dwell`+1 cycles
- `phase_init` in FREQ_W: phase word applied for the sweep
- `freq` out FREQ_W: to `dds.freq`
- `phase` out FREQ_W: to `dds.phase`
- `dac_en` out 1: to `dsdac.en`
- `busy` out 1: high in every state but IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- Reset: state IDLE, `freq`=0, `phase`=0, `dac_en`=0, `busy`=0, `done`=0, counters 0.
- IDLE: on `start`, latch `f_start/f_stop/f_step/dwell/phase_init`; load `freq`←`f_start`, `phase`←`phase_init` → SETTLE. Inputs ignored otherwise; `freq` holds its last value.
- SETTLE: `dac_en`=0; counts SETTLE_CYC cycles → SWEEP_UP, dwell counter loaded with `dwell`.
- SWEEP_UP: `dac_en`=1. Dwell counter decrements; at 0: if `freq`==latched `f_stop` or `freq`>`f_stop` → DONE (or SWEEP_DN, see Configuration); else `freq`←min(`freq`+`f_step`, `f_stop`) using FREQ_W+1-bit sum (no wrap), counter reloaded.
- `f_start`≥`f_stop`: single tone at `f_start` for `dwell`+1 cycles, then DONE.
- DONE: `done`=1 for exactly this cycle, `dac_en` stays 1. If `loop`: `freq`←`f_start`, → SWEEP_UP (no settle). Else → IDLE, `dac_en`←0.
- `abort` (any non-IDLE state): → IDLE next cycle, `dac_en`=0, no `done` pulse; `freq` holds. Abort has priority over all transitions.
- `start` while `busy` ignored; `start` and `abort` together in IDLE: abort wins, stay IDLE.
- Reset asserted mid-sweep: all outputs to reset values immediately (async).

## Timing
- `start` sampled at edge 0 → `busy`=1, `freq`=`f_start` after edge 0.
- `dac_en` rises after edge SETTLE_CYC.
- Each frequency value present for `dwell`+1 cycles with `dac_en`=1; final (`f_stop`) value also dwells fully.
- `done` asserted the cycle after the final dwell expires; `busy` falls the cycle after `done` (no loop).
- All outputs registered; no combinational input→output paths.

## Configuration
- `DDS_SWEEP_TRIANGLE_EN` defined: after final up-dwell, state SWEEP_DN steps `freq`←max(`freq`−`f_step`, `f_start`) with same dwell; DONE entered after `f_start` dwell. Point `f_stop` is not repeated.
- Undefined: SWEEP_DN absent; up-sweep only.

## Structure
- Shared `dds_pkg`: state enum (IDLE, SETTLE, SWEEP_UP, SWEEP_DN, DONE), default FREQ_W/DWELL_W constants.
- One sub-module `dwell_timer`: loadable down-counter with `load`, `value`, `expired` output; instantiated for dwell and reused for settle count.

## Test plan
- `f_start`=157482, `f_stop`=157482+3·1000, `f_step`=1000, `dwell`=3, SETTLE_CYC=8 → 4 freq values, 4 cycles each, `dac_en` up at cycle 8, `done` at cycle 24.
- `f_stop` not step-aligned (`f_step`=1000, span 2500) → sequence start, +1000, +2000, `f_stop`; no overshoot.
- `f_start`=0xFFFF_FF00, `f_stop`=0xFFFF_FFFF, `f_step`=0x80 → saturates at 0xFFFF_FFFF, no wrap to 0.
- `abort` during SWEEP_UP step 2 → IDLE next cycle, `dac_en`=0, `done` never pulses; `start` during sweep ignored.
- `loop`=1 → after `done`, `freq` returns to `f_start` next cycle with `dac_en` held 1; `rst_n` low mid-sweep → all outputs 0 asynchronously.
- With `DDS_SWEEP_TRIANGLE_EN`, span 3 steps → up 4 values then down 3 values, `done` after `f_start` dwell.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default widths for the dds tone-generator control path.
// Combinational constants only; no timing or flow-control behaviour.
package dds_pkg;

    localparam int FREQ_W_DEF  = 32;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        SWEEP_UP = 3'd2,
        SWEEP_DN = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
// Load takes effect on the next edge; the count stops at zero until reloaded.
module dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer for dds/dsdac; all outputs registered, busy/freq valid one edge after start, no backpressure.
// Define DDS_SWEEP_TRIANGLE_EN to sweep back down to the start frequency before completing.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FREQ_W     = FREQ_W_DEF,
    parameter int DWELL_W    = DWELL_W_DEF,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [FREQ_W-1:0] f_start,
    input  logic [FREQ_W-1:0] f_stop,
    input  logic [FREQ_W-1:0] f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [FREQ_W-1:0] phase_init,
    output logic [FREQ_W-1:0] freq,
    output logic [FREQ_W-1:0] phase,
    output logic              dac_en,
    output logic              busy,
    output logic              done
);

    localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYC - 1);
    localparam logic [FREQ_W-1:0]  STEP_ONE    = FREQ_W'(1);

    state_t              r_state;
    logic [FREQ_W-1:0]   r_f_start;
    logic [FREQ_W-1:0]   r_f_stop;
    logic [FREQ_W-1:0]   r_f_step;
    logic [DWELL_W-1:0]  r_dwell;
    logic [FREQ_W-1:0]   r_freq;
    logic [FREQ_W-1:0]   r_phase;
    logic                r_dac_en;
    logic                r_busy;
    logic                r_done;

    logic                w_tmr_load;
    logic [DWELL_W-1:0]  w_tmr_value;
    logic                w_tmr_exp;
    logic [FREQ_W:0]     w_sum_up;
    logic [FREQ_W-1:0]   w_next_up;
    logic                w_at_top;

    // One timer serves both the settle window and every dwell; in DONE it is
    // held loaded so a loop restart begins a full dwell immediately.
    assign w_tmr_load  = (r_state == IDLE) ? (start & ~abort)
                                           : (w_tmr_exp | (r_state == DONE));
    assign w_tmr_value = (r_state == IDLE) ? SETTLE_LOAD : r_dwell;

    dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_exp)
    );

    // Widened sum so a step near the top of the range saturates at f_stop
    // instead of wrapping to a low frequency.
    assign w_sum_up  = {1'b0, r_freq} + {1'b0, r_f_step};
    assign w_next_up = (w_sum_up >= {1'b0, r_f_stop}) ? r_f_stop : w_sum_up[FREQ_W-1:0];
    assign w_at_top  = (r_freq >= r_f_stop);

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic [FREQ_W-1:0]   w_gap_dn;
    logic [FREQ_W-1:0]   w_next_dn;
    logic                w_at_bot;

    assign w_gap_dn  = r_freq - r_f_start;
    assign w_next_dn = (w_gap_dn <= r_f_step) ? r_f_start : (r_freq - r_f_step);
    assign w_at_bot  = (r_freq <= r_f_start);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_freq    <= '0;
            r_phase   <= '0;
            r_dac_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state  <= IDLE;
                r_dac_en <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !abort) begin
                            r_f_start <= f_start;
                            r_f_stop  <= f_stop;
                            r_f_step  <= (f_step == '0) ? STEP_ONE : f_step;
                            r_dwell   <= dwell;
                            r_freq    <= f_start;
                            r_phase   <= phase_init;
                            r_busy    <= 1'b1;
                            r_state   <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (w_tmr_exp) begin
                            r_dac_en <= 1'b1;
                            r_state  <= SWEEP_UP;
                        end
                    end
                    SWEEP_UP: begin
                        if (w_tmr_exp) begin
                            if (w_at_top) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                                if (r_f_start >= r_f_stop) begin
                                    r_done  <= 1'b1;
                                    r_state <= DONE;
                                end else begin
                                    r_freq  <= w_next_dn;
                                    r_state <= SWEEP_DN;
                                end
`else
                                r_done  <= 1'b1;
                                r_state <= DONE;
`endif
                            end else begin
                                r_freq <= w_next_up;
                            end
                        end
                    end
`ifdef DDS_SWEEP_TRIANGLE_EN
                    SWEEP_DN: begin
                        if (w_tmr_exp) begin
                            if (w_at_bot) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_freq <= w_next_dn;
                            end
                        end
                    end
`endif
                    DONE: begin
                        if (loop) begin
                            r_freq  <= r_f_start;
                            r_state <= SWEEP_UP;
                        end else begin
                            r_dac_en <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    default: begin
                        r_dac_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign freq   = r_freq;
    assign phase  = r_phase;
    assign dac_en = r_dac_en;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed and randomized checks of dds_sweep_ctrl against a list-based sweep model.
// Each cycle after start is compared against the expected frequency list expanded by dwell.
module tb_dds_sweep_ctrl;

    localparam int SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loop = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [31:0] phase_init = '0;
    logic [31:0] freq;
    logic [31:0] phase;
    logic        dac_en;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] seq[$];

    dds_sweep_ctrl #(
        .FREQ_W     (32),
        .DWELL_W    (16),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .loop       (loop),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .phase_init (phase_init),
        .freq       (freq),
        .phase      (phase),
        .dac_en     (dac_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ordered list of frequencies the sweep should visit, each held dwell+1 cycles.
    function automatic void build_seq(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st);
        longint unsigned v, stp, lo, hi;
        seq.delete();
        stp = (st == 0) ? 1 : longint'(st);
        lo  = longint'(fs);
        hi  = longint'(fe);
        v   = lo;
        seq.push_back(fs);
        if (lo < hi) begin
            while (v < hi) begin
                v = (v + stp >= hi) ? hi : v + stp;
                seq.push_back(v[31:0]);
            end
`ifdef DDS_SWEEP_TRIANGLE_EN
            while (v > lo) begin
                v = (v - lo <= stp) ? lo : v - stp;
                seq.push_back(v[31:0]);
            end
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] ef, input logic [31:0] ep,
                       input logic ed, input logic eb, input logic edn);
        vectors++;
        assert (freq === ef) else begin
            miscompares++;
            $error("FAIL %s freq observed %h expected %h", tag, freq, ef);
        end
        vectors++;
        assert (phase === ep) else begin
            miscompares++;
            $error("FAIL %s phase observed %h expected %h", tag, phase, ep);
        end
        vectors++;
        assert (dac_en === ed) else begin
            miscompares++;
            $error("FAIL %s dac_en observed %b expected %b", tag, dac_en, ed);
        end
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL %s busy observed %b expected %b", tag, busy, eb);
        end
        vectors++;
        assert (done === edn) else begin
            miscompares++;
            $error("FAIL %s done observed %b expected %b", tag, done, edn);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues start, scrambles the program inputs to prove they were latched,
    // then checks every cycle through the done pulse and the return to idle.
    task automatic run_sweep(input string tag, input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [15:0] dw, input logic [31:0] ph);
        logic [31:0] last;
        build_seq(fs, fe, st);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; phase_init = ph;
        start = 1'b1;
        step();
        start = 1'b0;
        f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'($urandom); phase_init = $urandom;
        for (int k = 0; k < SETTLE; k++) begin
            chk({tag, "_settle"}, fs, ph, 1'b0, 1'b1, 1'b0);
            step();
        end
        foreach (seq[i]) begin
            for (int d = 0; d <= int'(dw); d++) begin
                chk({tag, "_sweep"}, seq[i], ph, 1'b1, 1'b1, 1'b0);
                step();
            end
        end
        last = seq[seq.size()-1];
        chk({tag, "_done"}, last, ph, 1'b1, 1'b1, 1'b1);
        step();
        chk({tag, "_idle"}, last, ph, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] fs, st, fe, ph, last;
        logic [15:0] dw;
        longint unsigned e;

        // reset state
        step();
        step();
        chk("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("reset_release", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // start and abort together in IDLE: abort wins
        f_start = 32'h1234; phase_init = 32'h55;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("idle_start_abort", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("idle_stays", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        run_sweep("plan_basic", 32'd157482, 32'd160482, 32'd1000, 16'd3, 32'hA5A5_0001);
        run_sweep("unaligned", 32'd20000, 32'd22500, 32'd1000, 16'd2, 32'h0000_0100);
        run_sweep("saturate", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 32'h7);
        run_sweep("single_tone", 32'd9000, 32'd4000, 32'd100, 16'd4, 32'h11);
        run_sweep("equal_tone", 32'd777, 32'd777, 32'd5, 16'd0, 32'h22);
        run_sweep("step_zero", 32'd100, 32'd103, 32'd0, 16'd0, 32'h33);

        // abort during the second frequency step; start mid-sweep is ignored
        f_start = 32'd1000; f_stop = 32'd10000; f_step = 32'd1000; dwell = 16'd3; phase_init = 32'h44;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 9) begin
                f_start = 32'd50; start = 1'b1;
            end
            if (k == 11) start = 1'b0;
            if (k < SETTLE) chk("abort_settle", 32'd1000, 32'h44, 1'b0, 1'b1, 1'b0);
            else chk("abort_sweep", 32'd1000 + 32'((k - SETTLE) / 4) * 32'd1000, 32'h44, 1'b1, 1'b1, 1'b0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("abort_idle", 32'd2000, 32'h44, 1'b0, 1'b0, 1'b0);
            step();
        end

        // loop restart without settle, then asynchronous reset mid-sweep
        build_seq(32'd5000, 32'd7000, 32'd1000);
        f_start = 32'd5000; f_stop = 32'd7000; f_step = 32'd1000; dwell = 16'd1; phase_init = 32'h99;
        loop = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        f_start = 32'd1;
        for (int k = 0; k < SETTLE; k++) begin
            chk("loop_settle", 32'd5000, 32'h99, 1'b0, 1'b1, 1'b0);
            step();
        end
        foreach (seq[i]) begin
            for (int d = 0; d < 2; d++) begin
                chk("loop_sweep", seq[i], 32'h99, 1'b1, 1'b1, 1'b0);
                step();
            end
        end
        last = seq[seq.size()-1];
        chk("loop_done", last, 32'h99, 1'b1, 1'b1, 1'b1);
        step();
        chk("loop_restart", 32'd5000, 32'h99, 1'b1, 1'b1, 1'b0);
        step();
        chk("loop_dwell", 32'd5000, 32'h99, 1'b1, 1'b1, 1'b0);
        step();
        chk("loop_step", 32'd6000, 32'h99, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        loop = 1'b0;
        step();
        chk("reset_held", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("after_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // randomized programs
        for (int n = 0; n < 20; n++) begin
            fs = $urandom;
            st = $urandom_range(0, 3000);
            e  = longint'(fs) + longint'($urandom_range(0, 6)) * ((st == 0) ? 1 : longint'(st))
                 + longint'($urandom_range(0, (st == 0) ? 0 : st - 1));
            if (e > 64'h0000_0000_FFFF_FFFF) e = 64'h0000_0000_FFFF_FFFF;
            fe = e[31:0];
            if ($urandom_range(0, 4) == 0) fe = fs >> 1;
            dw = 16'($urandom_range(0, 4));
            ph = $urandom;
            run_sweep("random", fs, fe, st, dw, ph);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
